// File: rtl/mult_div_sequencer.sv
// mult_div_sequencer
//   Iterative signed multiply / divide engine for MIPS mult, div and mul.
//   One shared 2*WIDTH accumulator performs either add-and-shift (multiply)
//   or restoring shift-subtract (divide), one step per clock, WIDTH steps.
//   Fixed latency: start accepted in cycle 0, done pulse in cycle WIDTH+3.
//
// Ports
//   CLK            clock, rising edge
//   RST            synchronous active-high reset
//   mult_start     start signed op_a * op_b (wins over div_start)
//   div_start      start signed op_a / op_b
//   op_a, op_b     operands, sampled only when a start is accepted
//   busy           high whenever the engine is not idle
//   mult_div_done  one-cycle pulse, results valid from this cycle on
//   hi_result      product upper half / remainder
//   lo_result      product lower half / quotient
//   div_by_zero    set with done for a divide by zero, cleared on next start
module mult_div_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             mult_start,
    input  logic             div_start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             mult_div_done,
    output logic [WIDTH-1:0] hi_result,
    output logic [WIDTH-1:0] lo_result,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_RUN,
        S_FIX,
        S_DONE
    } state_t;

    // Operation request captured at start
    typedef struct packed {
        logic             is_div;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } req_t;

    state_t             state, next_state;
    req_t               req_q;
    logic [WIDTH-1:0]   mag_a;      // multiplicand / unused by divide step
    logic [WIDTH-1:0]   mag_b;      // divisor magnitude
    logic [2*WIDTH-1:0] acc;
    logic [CW-1:0]      cnt;
    logic               neg_q;      // product or quotient must be negated
    logic               neg_r;      // remainder must be negated (dividend < 0)

    // control decodes
    logic accept, start_div, do_prep, do_step, do_fix, busy_nxt, done_nxt;

    // Two's-complement magnitude. For the most negative value the result is
    // 2^(WIDTH-1), which is exact as an unsigned WIDTH-bit number.
    function automatic logic [WIDTH-1:0] abs_w(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? (~v + WIDTH'(1)) : v;
    endfunction

    function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
        return ~v + WIDTH'(1);
    endfunction

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge CLK) begin
        if (RST) state <= S_IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: if (mult_start || div_start) next_state = S_PREP;
            S_PREP: next_state = S_RUN;
            S_RUN:  if (cnt == '0) next_state = S_FIX;
            S_FIX:  next_state = S_DONE;
            S_DONE: next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    always_comb begin
        accept    = (state == S_IDLE) && (mult_start || div_start);
        start_div = div_start && !mult_start;   // multiply wins a tie
        do_prep   = (state == S_PREP);
        do_step   = (state == S_RUN);
        do_fix    = (state == S_FIX);
        // busy/done are registered from the upcoming state so they line up
        // with the state they describe
        busy_nxt  = (next_state != S_IDLE);
        done_nxt  = (next_state == S_DONE);
    end

    // ------------------------------------------------------- step datapath
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH+1:0]   div_diff;
    logic [2*WIDTH-1:0] div_next;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;
    logic               dbz_fix;

    always_comb begin
        // Multiply: acc = {partial product, remaining multiplier bits}.
        // Add multiplicand into the upper half when the current multiplier
        // LSB is set, keep the carry, then shift the whole thing right.
        mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} +
                   (acc[0] ? {1'b0, mag_a} : {(WIDTH+1){1'b0}});
        mul_next = {mul_sum, acc[WIDTH-1:1]};

        // Divide: acc = {partial remainder, dividend bits -> quotient bits}.
        // Shift left one, trial-subtract the divisor; keep the difference
        // only when it does not borrow.
        div_shift = acc[2*WIDTH-1:WIDTH-1];
        div_diff  = {1'b0, div_shift} - {2'b00, mag_b};
        if (!div_diff[WIDTH+1])
            div_next = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        else
            div_next = {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};

        // Sign fix-up
        prod_fix = neg_q ? (~acc + (2*WIDTH)'(1)) : acc;
        quo_fix  = neg_q ? neg_w(acc[WIDTH-1:0]) : acc[WIDTH-1:0];
        rem_fix  = neg_r ? neg_w(acc[2*WIDTH-1:WIDTH]) : acc[2*WIDTH-1:WIDTH];
        dbz_fix  = req_q.is_div && (req_q.b == '0);
    end

    // ------------------------------------------------------------ registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            req_q         <= '0;
            mag_a         <= '0;
            mag_b         <= '0;
            acc           <= '0;
            cnt           <= '0;
            neg_q         <= 1'b0;
            neg_r         <= 1'b0;
            busy          <= 1'b0;
            mult_div_done <= 1'b0;
            hi_result     <= '0;
            lo_result     <= '0;
            div_by_zero   <= 1'b0;
        end else begin
            busy          <= busy_nxt;
            mult_div_done <= done_nxt;

            if (accept) begin
                req_q.is_div <= start_div;
                req_q.a      <= op_a;
                req_q.b      <= op_b;
                div_by_zero  <= 1'b0;
            end

            if (do_prep) begin
                mag_a <= abs_w(req_q.a);
                mag_b <= abs_w(req_q.b);
                neg_q <= req_q.a[WIDTH-1] ^ req_q.b[WIDTH-1];
                neg_r <= req_q.a[WIDTH-1];
                // Upper half starts cleared; the lower half carries the bits
                // consumed by the iteration (multiplier or dividend).
                acc   <= {{WIDTH{1'b0}},
                          req_q.is_div ? abs_w(req_q.a) : abs_w(req_q.b)};
                cnt   <= CW'(WIDTH - 1);
            end

            if (do_step) begin
                acc <= req_q.is_div ? div_next : mul_next;
                cnt <= cnt - 1'b1;
            end

            if (do_fix) begin
                if (!req_q.is_div) begin
                    hi_result <= prod_fix[2*WIDTH-1:WIDTH];
                    lo_result <= prod_fix[WIDTH-1:0];
                end else if (dbz_fix) begin
                    hi_result   <= req_q.a;
                    lo_result   <= '1;
                    div_by_zero <= 1'b1;
                end else begin
                    hi_result <= rem_fix;
                    lo_result <= quo_fix;
                end
            end
        end
    end

endmodule

// File: tb/tb_mult_div_sequencer.sv
// Self-checking bench for mult_div_sequencer: expected results are pushed to
// a scoreboard queue when an operation is issued and popped by a monitor when
// the done pulse is observed (also checking the done cycle).
module tb_mult_div_sequencer;

    localparam int W = 32;

    logic         CLK = 1'b0;
    logic         RST = 1'b1;
    logic         mult_start = 1'b0;
    logic         div_start  = 1'b0;
    logic [W-1:0] op_a = '0;
    logic [W-1:0] op_b = '0;
    logic         busy, mult_div_done, div_by_zero;
    logic [W-1:0] hi_result, lo_result;

    mult_div_sequencer #(.WIDTH(W)) dut (
        .CLK           (CLK),
        .RST           (RST),
        .mult_start    (mult_start),
        .div_start     (div_start),
        .op_a          (op_a),
        .op_b          (op_b),
        .busy          (busy),
        .mult_div_done (mult_div_done),
        .hi_result     (hi_result),
        .lo_result     (lo_result),
        .div_by_zero   (div_by_zero)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dbz;
        int           at;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0, n_err = 0, cyc = 0, done_cnt = 0, exp_dones = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation
    always @(negedge CLK) begin : mon
        exp_t e;
        if (mult_div_done === 1'b1) begin
            done_cnt++;
            if (sb.size() == 0) begin
                chk("unexpected_done", {63'd0, mult_div_done}, 64'd0);
            end else begin
                e = sb.pop_front();
                chk("hi", {32'd0, hi_result}, {32'd0, e.hi});
                chk("lo", {32'd0, lo_result}, {32'd0, e.lo});
                chk("dbz", {63'd0, div_by_zero}, {63'd0, e.dbz});
                chk("done_cycle", 64'(cyc), 64'(e.at));
            end
        end
    end

    // Reference model, computed in 64-bit signed arithmetic
    function automatic void model(input bit m, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] hi, output logic [W-1:0] lo,
                                  output logic dbz);
        longint sa, sbv, p, q, r;
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        dbz = 1'b0;
        if (m) begin
            p  = sa * sbv;
            hi = p[63:32];
            lo = p[31:0];
        end else if (b == '0) begin
            hi  = a;
            lo  = '1;
            dbz = 1'b1;
        end else begin
            q  = sa / sbv;
            r  = sa % sbv;
            hi = r[31:0];
            lo = q[31:0];
        end
    endfunction

    // Drive a start for one cycle; returns in cycle 1 (PREP) of the operation
    task automatic issue(input bit m, input bit d, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] ehi, input logic [W-1:0] elo, input logic edbz);
        exp_t e;
        @(posedge CLK); #1;
        mult_start = m; div_start = d; op_a = a; op_b = b;
        @(posedge CLK); #1;
        mult_start = 1'b0; div_start = 1'b0;
        e.hi = ehi; e.lo = elo; e.dbz = edbz;
        e.at = cyc + 34;            // now in cycle 1, done due in cycle 35
        sb.push_back(e);
        exp_dones++;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (sb.size() != 0 && n < 60) begin
            @(negedge CLK);
            n++;
        end
        if (sb.size() != 0) begin
            chk("timeout", 64'(sb.size()), 64'd0);
            sb.delete();
        end
        chk("done_count", 64'(done_cnt), 64'(exp_dones));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] ra, rb, eh, el;
        logic         ed;
        bit           rm;

        // Reset, with a start held during reset that must be ignored
        mult_start = 1'b1; op_a = 32'd5; op_b = 32'd6;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, mult_div_done}, 64'd0);
        chk("rst_hi", {32'd0, hi_result}, 64'd0);
        chk("rst_lo", {32'd0, lo_result}, 64'd0);
        chk("rst_dbz", {63'd0, div_by_zero}, 64'd0);
        mult_start = 1'b0;
        @(posedge CLK); #1;
        RST = 1'b0;
        @(negedge CLK);
        chk("post_rst_idle", {63'd0, busy}, 64'd0);

        // Mixed-sign multiply with busy profile and result hold
        issue(1, 0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 0);
        for (int n = 1; n <= 36; n++) begin
            @(negedge CLK);
            chk($sformatf("busy_c%0d", n), {63'd0, busy}, {63'd0, n <= 35});
        end
        chk("hold_hi", {32'd0, hi_result}, {32'd0, 32'hFFFF_FFFF});
        chk("hold_lo", {32'd0, lo_result}, {32'd0, 32'hFFFF_FFEB});
        wait_idle();

        // Most-negative multiply, then -1 * 1
        issue(1, 0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 0);
        wait_idle();
        issue(1, 0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        wait_idle();

        // Signed divides
        issue(0, 1, -32'sd7, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0);
        wait_idle();
        issue(0, 1, 32'd7, -32'sd2, 32'd1, 32'hFFFF_FFFD, 0);
        wait_idle();

        // Divide by zero, then a normal divide clears the flag, then overflow
        issue(0, 1, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1);
        wait_idle();
        issue(0, 1, 32'd9, 32'd3, 32'd0, 32'd3, 0);
        wait_idle();
        issue(0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 0);
        wait_idle();

        // Both starts high: multiply wins. Operands changed at cycle 5 and a
        // div_start at cycle 10 must have no effect.
        issue(1, 1, 32'd6, 32'd4, 32'd0, 32'd24, 0);
        repeat (4) @(posedge CLK);
        #1; op_a = 32'h1234_5678; op_b = 32'h0000_0000;
        repeat (5) @(posedge CLK);
        #1; div_start = 1'b1;
        @(posedge CLK); #1; div_start = 1'b0;
        wait_idle();
        repeat (40) @(negedge CLK);
        chk("single_done", 64'(done_cnt), 64'(exp_dones));
        chk("results_kept", {32'd0, lo_result}, 64'd24);

        // Reset in cycle 12 of a multiply
        issue(1, 0, 32'h0001_2345, 32'h0000_6789, 32'd0, 32'd0, 0);
        repeat (11) @(posedge CLK);
        #1; RST = 1'b1;
        @(posedge CLK); #1;
        sb.delete();
        exp_dones--;
        @(negedge CLK);
        chk("midrst_busy", {63'd0, busy}, 64'd0);
        chk("midrst_hi", {32'd0, hi_result}, 64'd0);
        chk("midrst_lo", {32'd0, lo_result}, 64'd0);
        chk("midrst_dbz", {63'd0, div_by_zero}, 64'd0);
        chk("midrst_done", {63'd0, mult_div_done}, 64'd0);
        #2; RST = 1'b0;
        repeat (40) @(negedge CLK);
        chk("no_done_after_rst", 64'(done_cnt), 64'(exp_dones));
        issue(1, 0, 32'd3, 32'd3, 32'd0, 32'd9, 0);
        wait_idle();

        // Random operations against the model (one divide by zero included)
        for (int i = 0; i < 8; i++) begin
            rm = i[0];
            ra = $urandom;
            rb = (i == 4) ? 32'd0 : $urandom;
            if (i == 6) rb = $urandom_range(1, 50);
            model(rm, ra, rb, eh, el, ed);
            issue(rm, !rm, ra, rb, eh, el, ed);
            wait_idle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
